cic_interp: RTL and testbench

CIC interpolator: the transmit-side counterpart of the AM chain's CIC decimator. It accepts 8-bit signed samples at a low rate `clk / interpolation_ratio`, paced by its own request strobe, and produces one 8-bit signed output sample every `clk`. It contains N comb stages at the low rate, zero-stuffing, and N integrators at the full rate, with a runtime-selectable ratio and power-of-two gain normalisation.

---
 rtl/cic_interp.sv | 110 +++++++++++
 tb/tb_cic_interp.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cic_interp.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing, N integrators
// at the full clock rate, and a power-of-two output normalisation.
module cic_interp #(
  parameter int N       = 3,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int RATIO_W = 16,
  parameter int W       = IN_W + N * RATIO_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RATIO_W-1:0]        interpolation_ratio,
  input  logic signed [IN_W-1:0]    d_in,
  output logic                      d_req,
  output logic signed [OUT_W-1:0]   d_out
);

  localparam int SH_W = $clog2((N - 1) * RATIO_W + 2);

  // Normalisation shift (N-1)*ceil(log2(r)); r = 0 and r = 1 both give 0.
  function automatic logic [SH_W-1:0] calc_shift(input logic [RATIO_W-1:0] r);
    int unsigned lg;
    lg = 0;
    for (int i = 0; i < RATIO_W; i++) begin
      if (((RATIO_W+1)'(1) << i) < {1'b0, r}) lg = i + 1;
    end
    return SH_W'((N - 1) * lg);
  endfunction

  // Floor scaling: arithmetic shift then keep the low OUT_W bits (gain <= 1, so it fits).
  function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [W-1:0] v,
                                                        input logic [SH_W-1:0]    s);
    logic signed [W-1:0] t;
    t = v >>> s;
    return t[OUT_W-1:0];
  endfunction

  logic [RATIO_W-1:0]  r_lat;
  logic [SH_W-1:0]     shift;
  logic [RATIO_W-1:0]  ph;

  logic signed [W-1:0] comb_p0 [N+1];
  logic signed [W-1:0] comb_dly [N];
  logic signed [W-1:0] u_p1;
  logic signed [W-1:0] integ_p2 [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat <= (interpolation_ratio == '0) ? RATIO_W'(1) : interpolation_ratio;
      shift <= calc_shift(interpolation_ratio);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= '0;
    end else if (ph >= r_lat - RATIO_W'(1)) begin
      ph <= '0;
    end else begin
      ph <= ph + RATIO_W'(1);
    end
  end

  assign d_req = !rst && (ph == '0);

  // Stage p0: comb chain on the accepted sample (combinational, low rate)
  always_comb begin
    comb_p0[0] = {{(W-IN_W){d_in[IN_W-1]}}, d_in};
    for (int k = 0; k < N; k++) begin
      comb_p0[k+1] = comb_p0[k] - comb_dly[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) comb_dly[k] <= '0;
    end else if (d_req) begin
      for (int k = 0; k < N; k++) comb_dly[k] <= comb_p0[k];
    end
  end

  // Stage p1: zero-stuffed comb output, non-zero for one cycle per input sample
  always_ff @(posedge clk) begin
    if (rst) begin
      u_p1 <= '0;
    end else begin
      u_p1 <= d_req ? comb_p0[N] : '0;
    end
  end

  // Stage p2: integrator chain at full rate; modulo-2^W wrap is intended
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) integ_p2[k] <= '0;
    end else begin
      integ_p2[0] <= integ_p2[0] + u_p1;
      for (int k = 1; k < N; k++) integ_p2[k] <= integ_p2[k] + integ_p2[k-1];
    end
  end

  // Output register: normalised last integrator
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
    end else begin
      d_out <= scale_out(integ_p2[N-1], shift);
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Randomised bench for cic_interp: output predicted by convolving the zero-stuffed
// input with the CIC impulse response (R-tap boxcar convolved N times).
module tb_cic_interp;
  localparam int N = 3;
  localparam int IN_W = 8;
  localparam int OUT_W = 8;
  localparam int RATIO_W = 16;
  localparam int LAT = N + 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [RATIO_W-1:0]       interpolation_ratio = 16'd4;
  logic signed [IN_W-1:0]   d_in = '0;
  logic                     d_req;
  logic signed [OUT_W-1:0]  d_out;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  cic_interp #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .RATIO_W(RATIO_W)) dut (
    .clk(clk),
    .rst(rst),
    .interpolation_ratio(interpolation_ratio),
    .d_in(d_in),
    .d_req(d_req),
    .d_out(d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 random, 1 impulse of val, 2 constant val, 3 ramp
  task automatic run_seq(input int ratio, input int nrst, input int ncyc,
                         input int mode, input int val, input int ratio_run);
    int r, lg, sh, k;
    int h[$];
    int nh[$];
    int samp[$];
    int s;
    longint y;
    logic signed [IN_W-1:0] x;
    logic signed [OUT_W-1:0] eo;
    logic er;

    r = (ratio == 0) ? 1 : ratio;
    lg = 0;
    while ((1 << lg) < r) lg++;
    sh = (N - 1) * lg;
    h = {};
    if (r <= 64) begin
      h.push_back(1);
      repeat (N) begin
        nh = {};
        for (int i = 0; i < h.size() + r - 1; i++) begin
          s = 0;
          for (int j = 0; j < r; j++)
            if (i - j >= 0 && i - j < h.size()) s += h[i - j];
          nh.push_back(s);
        end
        h = nh;
      end
    end

    for (int i = 0; i < nrst; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      interpolation_ratio = RATIO_W'(ratio);
      d_in = IN_W'($urandom);
      @(negedge clk);
      check("rst_d_req", d_req, 0);
      if (i > 0) check("rst_d_out", d_out, 0);
    end

    samp = {};
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      interpolation_ratio = RATIO_W'(ratio_run);
      case (mode)
        0: x = IN_W'($urandom);
        1: x = (t == 0) ? IN_W'(val) : '0;
        2: x = IN_W'(val);
        default: x = IN_W'(t);
      endcase
      d_in = x;
      @(negedge clk);
      er = ((t % r) == 0);
      check("d_req", d_req, er);
      if (er) samp.push_back(int'(x));
      y = 0;
      if (t >= LAT) begin
        for (int j = 0; j < samp.size(); j++) begin
          k = (t - LAT) - j * r;
          if (k >= 0 && k < h.size()) y += longint'(samp[j]) * longint'(h[k]);
        end
      end
      eo = OUT_W'(y >>> sh);
      check("d_out", d_out, eo);
    end
  endtask

  initial begin
    // impulse of 64 at R = 4 gives 4,12,24,40,48,48,40,24,12,4
    run_seq(4, 3, 24, 1, 64, 4);
    run_seq(4, 2, 30, 2, 100, 4);
    run_seq(4, 2, 30, 2, -128, 4);
    run_seq(3, 2, 30, 2, 100, 3);
    run_seq(0, 2, 20, 3, 0, 0);
    run_seq(1, 2, 20, 3, 0, 1);
    for (int n = 0; n < 6; n++) begin
      int rr;
      rr = int'($urandom_range(0, 9));
      run_seq(rr, 2, 60, 0, 0, rr);
    end
    // latched ratio ignores later port changes until a reset
    run_seq(12500, 3, 25010, 2, 0, 8);
    run_seq(8, 1, 40, 0, 0, 8);
    // mid-stream single-cycle reset during a DC run
    run_seq(4, 2, 30, 2, 100, 4);
    run_seq(4, 1, 30, 2, 100, 4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
